// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order alloc, out-of-order writeback, in-order retire of up to COMMIT_W/cycle.
// Writeback visible to commit next cycle; enq_ready drops when full or flushing; mispredict squashes all.
module rob_multi_commit #(
    parameter int DEPTH    = 32,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int NUM_WB   = 4,
    parameter int COMMIT_W = 2,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [DATA_W-1:0]          enq_pc,
    input  logic [4:0]                 enq_rd_addr,
    input  logic                       enq_regf_we,
    output logic [IDX_W-1:0]           enq_idx,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
    input  logic [NUM_WB-1:0]          wb_mispred,
    input  logic [NUM_WB*DATA_W-1:0]   wb_pc_new,
    output logic [COMMIT_W-1:0]        cmt_valid,
    output logic [COMMIT_W*5-1:0]      cmt_rd_addr,
    output logic [COMMIT_W-1:0]        cmt_regf_we,
    output logic [COMMIT_W*DATA_W-1:0] cmt_data,
    output logic [COMMIT_W*DATA_W-1:0] cmt_pc,
    output logic                       flush_o,
    output logic [DATA_W-1:0]          flush_pc,
    output logic [IDX_W:0]             count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    logic [DEPTH-1:0]  e_valid, e_done, e_mispred, e_we;
    logic [DATA_W-1:0] e_pc     [DEPTH];
    logic [DATA_W-1:0] e_data   [DEPTH];
    logic [DATA_W-1:0] e_pc_new [DEPTH];
    logic [4:0]        e_rd     [DEPTH];

    logic [IDX_W:0]    head, tail;
    logic [IDX_W:0]    n_cmt;
    logic [IDX_W-1:0]  s_idx;
    logic              chain;
    logic              flush_take;
    logic [DATA_W-1:0] flush_tgt;
    logic              enq_fire;

    assign count_o   = tail - head;
    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == (IDX_W+1)'(DEPTH));
    assign enq_ready = !full_o && !flush_o;
    assign enq_idx   = tail[IDX_W-1:0];
    assign enq_fire  = enq_valid && enq_ready;

    // Retire window: contiguous done entries from head, cut after the first mispredict.
    always_comb begin
        cmt_valid   = '0;
        cmt_rd_addr = '0;
        cmt_regf_we = '0;
        cmt_data    = '0;
        cmt_pc      = '0;
        n_cmt       = '0;
        flush_take  = 1'b0;
        flush_tgt   = '0;
        chain       = 1'b1;
        s_idx       = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            s_idx = head[IDX_W-1:0] + IDX_W'(k);
            cmt_valid[k] = chain && e_valid[s_idx] && e_done[s_idx] &&
                           (count_o > (IDX_W+1)'(k));
            cmt_rd_addr[k*5 +: 5]       = e_rd[s_idx];
            cmt_regf_we[k]              = e_we[s_idx];
            cmt_data[k*DATA_W +: DATA_W] = e_data[s_idx];
            cmt_pc[k*DATA_W +: DATA_W]   = e_pc[s_idx];
            if (cmt_valid[k]) begin
                n_cmt = n_cmt + 1'b1;
                if (e_mispred[s_idx]) begin
                    flush_take = 1'b1;
                    flush_tgt  = e_pc_new[s_idx];
                end
            end
            chain = cmt_valid[k] && !e_mispred[s_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            e_valid   <= '0;
            e_done    <= '0;
            e_mispred <= '0;
            flush_o   <= 1'b0;
            flush_pc  <= '0;
        end else begin
            flush_o <= flush_take;
            if (flush_take) begin
                flush_pc <= flush_tgt;
            end
            // Descending order so the lowest-numbered port's write lands last and wins.
            for (int p = NUM_WB-1; p >= 0; p--) begin
                if (wb_valid[p] && e_valid[wb_idx[p*IDX_W +: IDX_W]]) begin
                    e_done[wb_idx[p*IDX_W +: IDX_W]]    <= 1'b1;
                    e_data[wb_idx[p*IDX_W +: IDX_W]]    <= wb_data[p*DATA_W +: DATA_W];
                    e_mispred[wb_idx[p*IDX_W +: IDX_W]] <= wb_mispred[p];
                    e_pc_new[wb_idx[p*IDX_W +: IDX_W]]  <= wb_pc_new[p*DATA_W +: DATA_W];
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (cmt_valid[k]) begin
                    e_valid[head[IDX_W-1:0] + IDX_W'(k)]   <= 1'b0;
                    e_done[head[IDX_W-1:0] + IDX_W'(k)]    <= 1'b0;
                    e_mispred[head[IDX_W-1:0] + IDX_W'(k)] <= 1'b0;
                end
            end
            if (flush_take) begin
                e_valid   <= '0;
                e_done    <= '0;
                e_mispred <= '0;
                head      <= '0;
                tail      <= '0;
            end else begin
                head <= head + n_cmt;
                if (enq_fire) begin
                    e_valid[tail[IDX_W-1:0]]   <= 1'b1;
                    e_done[tail[IDX_W-1:0]]    <= 1'b0;
                    e_mispred[tail[IDX_W-1:0]] <= 1'b0;
                    e_pc[tail[IDX_W-1:0]]      <= enq_pc;
                    e_rd[tail[IDX_W-1:0]]      <= enq_rd_addr;
                    e_we[tail[IDX_W-1:0]]      <= enq_regf_we;
                    tail <= tail + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed scenarios plus a randomized run against a queue-based reference model of the ROB.
module tb_rob_multi_commit;
    localparam int DEPTH = 32, IDX_W = 5, NUM_WB = 4, COMMIT_W = 2, DATA_W = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic enq_valid = 1'b0, enq_ready, enq_regf_we = 1'b0;
    logic [DATA_W-1:0] enq_pc = '0;
    logic [4:0] enq_rd_addr = '0;
    logic [IDX_W-1:0] enq_idx;
    logic [NUM_WB-1:0] wb_valid = '0, wb_mispred = '0;
    logic [NUM_WB*IDX_W-1:0] wb_idx = '0;
    logic [NUM_WB*DATA_W-1:0] wb_data = '0, wb_pc_new = '0;
    logic [COMMIT_W-1:0] cmt_valid, cmt_regf_we;
    logic [COMMIT_W*5-1:0] cmt_rd_addr;
    logic [COMMIT_W*DATA_W-1:0] cmt_data, cmt_pc;
    logic flush_o, empty_o, full_o;
    logic [DATA_W-1:0] flush_pc;
    logic [IDX_W:0] count_o;

    int n_checks = 0, n_fail = 0;

    rob_multi_commit #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_rd_addr(enq_rd_addr), .enq_regf_we(enq_regf_we), .enq_idx(enq_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_mispred(wb_mispred),
        .wb_pc_new(wb_pc_new), .cmt_valid(cmt_valid), .cmt_rd_addr(cmt_rd_addr),
        .cmt_regf_we(cmt_regf_we), .cmt_data(cmt_data), .cmt_pc(cmt_pc), .flush_o(flush_o),
        .flush_pc(flush_pc), .count_o(count_o), .empty_o(empty_o), .full_o(full_o));

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        done;
        logic [31:0] data;
        logic        mp;
        logic [31:0] pn;
    } ent_t;
    ent_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = '0; wb_idx = '0; wb_data = '0; wb_mispred = '0; wb_pc_new = '0;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] d,
                          input logic mp, input logic [31:0] pn);
        wb_valid[p] = 1'b1;
        wb_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
        wb_data[p*DATA_W +: DATA_W] = d;
        wb_mispred[p] = mp;
        wb_pc_new[p*DATA_W +: DATA_W] = pn;
    endtask

    task automatic do_reset();
        rst = 1'b1; enq_valid = 1'b0; clear_wb();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic enq_n(input int n, input logic [31:0] pc_base);
        for (int i = 0; i < n; i++) begin
            enq_valid = 1'b1; enq_pc = pc_base + 32'(4*i);
            enq_rd_addr = 5'(i + 1); enq_regf_we = 1'b1;
            tick();
        end
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count_o !== 0 || empty_o !== 1'b1 || full_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_occ: count=%0d empty=%b full=%b, need 0/1/0", count_o, empty_o, full_o); end
        n_checks++; if (cmt_valid !== 2'b00 || flush_o !== 1'b0 || flush_pc !== 32'h0) begin n_fail++;
            $display("FAIL reset_out: cmt=%b flush=%b fpc=%h, need 00/0/0", cmt_valid, flush_o, flush_pc); end
        n_checks++; if (enq_ready !== 1'b1 || enq_idx !== 5'd0) begin n_fail++;
            $display("FAIL reset_enq: ready=%b idx=%0d, need 1/0", enq_ready, enq_idx); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h1000 + 32'(i); #1;
            n_checks++; if (enq_idx !== IDX_W'(i) || enq_ready !== 1'b1) begin n_fail++;
                $display("FAIL fill_idx: idx=%0d ready=%b, need %0d/1", enq_idx, enq_ready, i); end
            tick();
        end
        n_checks++; if (full_o !== 1'b1 || enq_ready !== 1'b0 || count_o !== 6'd32) begin n_fail++;
            $display("FAIL fill_full: full=%b ready=%b count=%0d, need 1/0/32", full_o, enq_ready, count_o); end
        tick();
        n_checks++; if (count_o !== 6'd32) begin n_fail++;
            $display("FAIL fill_hold: count=%0d, need 32", count_o); end
        enq_valid = 1'b0;
    endtask

    task automatic test_ooo_wb();
        do_reset();
        enq_n(4, 32'h100);
        for (int p = 0; p < 4; p++) set_wb(p, 3 - p, 32'hD0 + 32'(3 - p), 1'b0, 32'h0);
        tick(); clear_wb();
        n_checks++; if (cmt_valid !== 2'b11 || cmt_rd_addr !== {5'd2, 5'd1} ||
                        cmt_data !== {32'hD1, 32'hD0}) begin n_fail++;
            $display("FAIL ooo_first: cmt=%b rd=%h data=%h, need 11/0x41/d1,d0", cmt_valid, cmt_rd_addr, cmt_data); end
        tick();
        n_checks++; if (cmt_valid !== 2'b11 || cmt_data !== {32'hD3, 32'hD2} ||
                        cmt_pc !== {32'h10C, 32'h108}) begin n_fail++;
            $display("FAIL ooo_second: cmt=%b data=%h pc=%h", cmt_valid, cmt_data, cmt_pc); end
        tick();
        n_checks++; if (cmt_valid !== 2'b00 || empty_o !== 1'b1) begin n_fail++;
            $display("FAIL ooo_drain: cmt=%b empty=%b, need 00/1", cmt_valid, empty_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        enq_n(31, 32'h4000);
        n_checks++; if (count_o !== 6'd31 || enq_idx !== 5'd31) begin n_fail++;
            $display("FAIL wrap_fill: count=%0d idx=%0d, need 31/31", count_o, enq_idx); end
        for (int r = 0; r < 2; r++) begin
            set_wb(0, r, 32'h77, 1'b0, 32'h0);
            tick(); clear_wb();
            enq_valid = 1'b1; enq_pc = 32'h5000; #1;
            n_checks++; if (cmt_valid !== 2'b01 || enq_ready !== 1'b1 || enq_idx !== IDX_W'(31 + r)) begin
                n_fail++;
                $display("FAIL wrap_pre%0d: cmt=%b ready=%b idx=%0d", r, cmt_valid, enq_ready, enq_idx); end
            tick(); enq_valid = 1'b0;
            n_checks++; if (count_o !== 6'd31 || enq_idx !== IDX_W'(r) || full_o !== 1'b0) begin n_fail++;
                $display("FAIL wrap_post%0d: count=%0d idx=%0d full=%b, need 31/%0d/0", r, count_o, enq_idx, full_o, r); end
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        enq_n(3, 32'h2000);
        set_wb(0, 0, 32'h1, 1'b0, 32'h0);
        set_wb(1, 1, 32'h2, 1'b1, 32'h6000_0040);
        set_wb(2, 2, 32'h3, 1'b0, 32'h0);
        tick(); clear_wb();
        enq_valid = 1'b1; enq_pc = 32'h9999; #1;
        n_checks++; if (cmt_valid !== 2'b11 || cmt_pc !== {32'h2004, 32'h2000} || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL mp_retire: cmt=%b pc=%h flush=%b", cmt_valid, cmt_pc, flush_o); end
        tick(); enq_valid = 1'b0;
        n_checks++; if (flush_o !== 1'b1 || flush_pc !== 32'h6000_0040) begin n_fail++;
            $display("FAIL mp_flush: flush=%b pc=%h, need 1/60000040", flush_o, flush_pc); end
        n_checks++; if (count_o !== 0 || enq_idx !== 0 || cmt_valid !== 2'b00 || enq_ready !== 1'b0) begin
            n_fail++; $display("FAIL mp_squash: count=%0d idx=%0d cmt=%b ready=%b", count_o, enq_idx, cmt_valid, enq_ready); end
        tick();
        n_checks++; if (flush_o !== 1'b0 || count_o !== 0 || enq_ready !== 1'b1) begin n_fail++;
            $display("FAIL mp_after: flush=%b count=%0d ready=%b, need 0/0/1", flush_o, count_o, enq_ready); end
    endtask

    task automatic test_same_idx();
        logic [31:0] got;
        logic seen, any_flush;
        do_reset();
        enq_n(6, 32'h3000);
        for (int p = 0; p < 4; p++) set_wb(p, p, 32'h10 + 32'(p), 1'b0, 32'h0);
        tick(); clear_wb();
        set_wb(0, 5, 32'hAAAA, 1'b0, 32'h0);
        set_wb(1, 4, 32'h44, 1'b0, 32'h0);
        set_wb(2, 5, 32'hBBBB, 1'b0, 32'h0);
        set_wb(3, 20, 32'hDEAD, 1'b1, 32'hDEAD);
        tick(); clear_wb();
        got = '0; seen = 1'b0; any_flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < COMMIT_W; k++)
                if (cmt_valid[k] && cmt_pc[k*DATA_W +: DATA_W] == 32'h3014) begin
                    got = cmt_data[k*DATA_W +: DATA_W]; seen = 1'b1; end
            any_flush = any_flush | flush_o;
            tick();
        end
        n_checks++; if (!seen || got !== 32'hAAAA) begin n_fail++;
            $display("FAIL same_idx: seen=%b data=%h, need 1/aaaa", seen, got); end
        n_checks++; if (any_flush !== 1'b0 || count_o !== 0) begin n_fail++;
            $display("FAIL invalid_wb: flush=%b count=%0d, need 0/0", any_flush, count_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        enq_n(10, 32'h7000);
        for (int p = 0; p < 4; p++) set_wb(p, p, 32'h1, 1'b0, 32'h0);
        tick(); clear_wb();
        rst = 1'b1;
        tick();
        n_checks++; if (cmt_valid !== 2'b00 || empty_o !== 1'b1 || flush_o !== 1'b0) begin n_fail++;
            $display("FAIL midrst: cmt=%b empty=%b flush=%b, need 00/1/0", cmt_valid, empty_o, flush_o); end
        rst = 1'b0;
        tick();
        n_checks++; if (cmt_valid !== 2'b00 || count_o !== 0) begin n_fail++;
            $display("FAIL midrst_after: cmt=%b count=%0d, need 00/0", cmt_valid, count_o); end
    endtask

    task automatic test_random();
        int mtail, nret, wb_pct, pos, widx;
        logic mflush, mp_hit, exp_ready;
        logic [31:0] mflush_pc, mp_pn;
        logic [DEPTH-1:0] written;
        ent_t e;
        do_reset();
        q.delete(); mtail = 0; mflush = 1'b0; mflush_pc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wb_pct = ((cyc / 400) % 2 == 1) ? 15 : 60;
            enq_valid = ($urandom_range(0, 9) < 7);
            enq_pc = $urandom; enq_rd_addr = 5'($urandom); enq_regf_we = 1'($urandom);
            clear_wb();
            for (int p = 0; p < NUM_WB; p++)
                if ($urandom_range(0, 99) < wb_pct) begin
                    if (q.size() > 0 && $urandom_range(0, 4) != 0) widx = q[$urandom_range(0, q.size() - 1)].idx;
                    else widx = $urandom_range(0, DEPTH - 1);
                    set_wb(p, widx, $urandom, ($urandom_range(0, 59) == 0), $urandom);
                end
            #1;
            exp_ready = (q.size() < DEPTH) && !mflush;
            nret = 0; mp_hit = 1'b0; mp_pn = '0;
            for (int k = 0; k < COMMIT_W; k++)
                if (nret == k && !mp_hit && k < q.size() && q[k].done) begin
                    nret++;
                    if (q[k].mp) begin mp_hit = 1'b1; mp_pn = q[k].pn; end
                end
            n_checks++; if (enq_ready !== exp_ready || enq_idx !== IDX_W'(mtail) || count_o !== (IDX_W+1)'(q.size()) ||
                            empty_o !== (q.size() == 0) || full_o !== (q.size() == DEPTH)) begin n_fail++;
                $display("FAIL rnd_occ c%0d: ready=%b idx=%0d count=%0d, need %b/%0d/%0d", cyc, enq_ready, enq_idx, count_o, exp_ready, mtail, q.size()); end
            n_checks++; if (flush_o !== mflush || (mflush && flush_pc !== mflush_pc)) begin n_fail++;
                $display("FAIL rnd_flush c%0d: flush=%b pc=%h, need %b/%h", cyc, flush_o, flush_pc, mflush, mflush_pc); end
            n_checks++; if (cmt_valid !== COMMIT_W'((1 << nret) - 1)) begin n_fail++;
                $display("FAIL rnd_cmt c%0d: cmt=%b, need %0d retirements", cyc, cmt_valid, nret); end
            for (int k = 0; k < nret; k++) begin
                n_checks++;
                if (cmt_rd_addr[k*5 +: 5] !== q[k].rd || cmt_regf_we[k] !== q[k].we ||
                    cmt_data[k*DATA_W +: DATA_W] !== q[k].data || cmt_pc[k*DATA_W +: DATA_W] !== q[k].pc) begin
                    n_fail++;
                    $display("FAIL rnd_slot%0d c%0d: rd=%0d data=%h pc=%h, need %0d/%h/%h", k, cyc,
                             cmt_rd_addr[k*5 +: 5], cmt_data[k*DATA_W +: DATA_W], cmt_pc[k*DATA_W +: DATA_W], q[k].rd, q[k].data, q[k].pc);
                end
            end
            // Reference update for this edge: writebacks, retire, then flush or enqueue.
            written = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (!wb_valid[p]) continue;
                pos = -1;
                for (int i = 0; i < q.size(); i++) if (q[i].idx == int'(wb_idx[p*IDX_W +: IDX_W])) pos = i;
                if (pos >= 0 && !written[pos]) begin
                    written[pos] = 1'b1;
                    q[pos].done = 1'b1; q[pos].data = wb_data[p*DATA_W +: DATA_W];
                    q[pos].mp = wb_mispred[p]; q[pos].pn = wb_pc_new[p*DATA_W +: DATA_W];
                end
            end
            for (int k = 0; k < nret; k++) void'(q.pop_front());
            if (mp_hit) begin
                q.delete(); mtail = 0; mflush = 1'b1; mflush_pc = mp_pn;
            end else begin
                mflush = 1'b0;
                if (enq_valid && exp_ready) begin
                    e.idx = mtail; e.pc = enq_pc; e.rd = enq_rd_addr; e.we = enq_regf_we;
                    e.done = 1'b0; e.data = '0; e.mp = 1'b0; e.pn = '0;
                    q.push_back(e);
                    mtail = (mtail + 1) % DEPTH;
                end
            end
            tick();
        end
        enq_valid = 1'b0; clear_wb();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_ooo_wb();
        test_wrap();
        test_mispredict();
        test_same_idx();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
